// File: rtl/rr_mux_n.sv
// rr_mux_n: registered N-channel selector with valid/ready handshaking.
// Fixed mode routes the channel named by sel. Round-robin mode rotates
// priority, starting just above the last granted channel.
// Optional feature macro: RR_MUX_STALL_CNT_EN enables the saturating
// output-stall counter on stall_cnt. When the macro is undefined,
// stall_cnt is tied to zero.
module rr_mux_n #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [15:0]               stall_cnt
);

  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    gidx;
  logic [WIDTH-1:0]    gdata;
  logic [SEL_W-1:0]    ptr;
  logic                can_load;
  logic                accept;

  logic [WIDTH-1:0]    data_p0;
  logic [SEL_W-1:0]    chan_p0;
  logic                vld_p0;

  // The register can take a new word when it is empty or being drained this cycle.
  assign can_load = !vld_p0 || out_ready;
  assign in_ready = (can_load && !reset) ? grant : '0;
  assign accept   = |in_ready;

  // Grant selection: one-hot or zero. Out-of-range sel never matches a channel.
  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    if (!mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (i == int'(sel) && in_valid[i]) begin
          grant[i] = 1'b1;
          gidx     = SEL_W'(i);
        end
      end
    end else begin
      for (int k = 1; k <= CHANNELS; k++) begin
        idx = (int'(ptr) + k) % CHANNELS;
        if (!found && in_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          gidx       = SEL_W'(idx);
        end
      end
    end
  end

  // Data selection driven directly by the one-hot grant.
  always_comb begin
    gdata = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant[i]) gdata = in_data[i*WIDTH +: WIDTH];
    end
  end

  // ---- stage p0: output register, load on accept, empty on drain ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      chan_p0 <= '0;
    end else if (accept) begin
      vld_p0  <= 1'b1;
      data_p0 <= gdata;
      chan_p0 <= gidx;
    end else if (out_ready) begin
      vld_p0  <= 1'b0;
    end
  end

  // Round-robin pointer remembers the last channel granted in round-robin mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= SEL_W'(CHANNELS - 1);
    end else if (accept && mode) begin
      ptr <= gidx;
    end
  end

  assign out_data  = data_p0;
  assign out_chan  = chan_p0;
  assign out_valid = vld_p0;

`ifdef RR_MUX_STALL_CNT_EN
  logic [15:0] stall_p0;

  // Count cycles where a held word is refused by the sink, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_p0 <= '0;
    end else if (vld_p0 && !out_ready && stall_p0 != 16'hFFFF) begin
      stall_p0 <= stall_p0 + 16'd1;
    end
  end

  assign stall_cnt = stall_p0;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_rr_mux_n.sv
// Directed testbench for rr_mux_n: a 4-channel instance plus a 3-channel
// instance used for the out-of-range select case.
module tb_rr_mux_n;

  logic        clk = 1'b0;
  logic        reset;

  logic [127:0] in_data;
  logic [3:0]   in_valid;
  logic [3:0]   in_ready;
  logic         mode;
  logic [1:0]   sel;
  logic [31:0]  out_data;
  logic [1:0]   out_chan;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  stall_cnt;

  logic [95:0]  in_data2;
  logic [2:0]   in_valid2;
  logic [2:0]   in_ready2;
  logic         mode2;
  logic [1:0]   sel2;
  logic [31:0]  out_data2;
  logic [1:0]   out_chan2;
  logic         out_valid2;
  logic         out_ready2;
  logic [15:0]  stall_cnt2;

  int total = 0;
  int bad   = 0;

`ifdef RR_MUX_STALL_CNT_EN
  localparam int STALL_EXP = 5;
`else
  localparam int STALL_EXP = 0;
`endif

  always #5 clk = ~clk;

  rr_mux_n #(.WIDTH(32), .CHANNELS(4), .SEL_W(2)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready),
    .stall_cnt(stall_cnt)
  );

  rr_mux_n #(.WIDTH(32), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .mode(mode2), .sel(sel2), .out_data(out_data2),
    .out_chan(out_chan2), .out_valid(out_valid2), .out_ready(out_ready2),
    .stall_cnt(stall_cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_fixed [4] = '{10, 100, 0, 200};
    int e;

    reset      = 1'b1;
    in_data    = {32'd200, 32'd0, 32'd100, 32'd10};
    in_valid   = 4'b0000;
    mode       = 1'b0;
    sel        = 2'd0;
    out_ready  = 1'b0;
    in_data2   = {32'd30, 32'd20, 32'd10};
    in_valid2  = 3'b000;
    mode2      = 1'b0;
    sel2       = 2'd0;
    out_ready2 = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_chan",  64'(out_chan),  64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);

    // Fixed mode, sel stepped 0..3
    mode      = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      chk("fix_in_ready", 64'(in_ready), 64'(4'b0001 << s));
      tick();
      chk("fix_out_data",  64'(out_data),  64'(exp_fixed[s]));
      chk("fix_out_chan",  64'(out_chan),  64'(s));
      chk("fix_out_valid", 64'(out_valid), 64'd1);
    end

    // Round-robin, all valid: 0,1,2,3,0 back to back
    mode = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_all_in_ready", 64'(in_ready), 64'(4'b0001 << (k % 4)));
      tick();
      chk("rr_all_out_chan",  64'(out_chan),  64'(k % 4));
      chk("rr_all_out_valid", 64'(out_valid), 64'd1);
    end

    // Round-robin, channels 1 and 3 only: 1,3,1,3
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      e = (k % 2 == 1) ? 3 : 1;
      #1;
      chk("rr_13_in_ready", 64'(in_ready), 64'(4'b0001 << e));
      tick();
      chk("rr_13_out_chan", 64'(out_chan), 64'(e));
    end
    chk("rr_13_out_data", 64'(out_data), 64'd200);

    // Backpressure for 5 cycles
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
      chk("bp_out_data",  64'(out_data),  64'd200);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    chk("bp_stall_cnt", 64'(stall_cnt), 64'(STALL_EXP));
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'b0010);
    tick();
    chk("bp_release_out_chan",  64'(out_chan),  64'd1);
    chk("bp_release_out_data",  64'(out_data),  64'd100);
    chk("bp_release_out_valid", 64'(out_valid), 64'd1);
    chk("bp_release_stall_cnt", 64'(stall_cnt), 64'(STALL_EXP));

    // Empty: nothing valid, output drains
    in_valid = 4'b0000;
    #1;
    chk("empty_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("empty_out_valid", 64'(out_valid), 64'd0);
    chk("empty_out_data",  64'(out_data),  64'd100);

    // Reset while a word is held under backpressure
    in_valid  = 4'b1000;
    out_ready = 1'b0;
    tick();
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_out_data",  64'(out_data),  64'd200);
    in_valid = 4'b1111;
    reset    = 1'b1;
    #1;
    chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
    tick();
    reset = 1'b0;
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_out_data",  64'(out_data),  64'd0);
    chk("rst_mid_out_chan",  64'(out_chan),  64'd0);
    chk("rst_mid_stall_cnt", 64'(stall_cnt), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("rst_mid_rr_in_ready", 64'(in_ready), 64'b0001);
    tick();
    chk("rst_mid_rr_out_chan", 64'(out_chan), 64'd0);
    chk("rst_mid_rr_out_data", 64'(out_data), 64'd10);

    // Three-channel instance, sel beyond the channel count
    in_valid2 = 3'b111;
    sel2      = 2'd3;
    #1;
    chk("c3_sel3_in_ready", 64'(in_ready2), 64'd0);
    tick();
    chk("c3_sel3_out_valid", 64'(out_valid2), 64'd0);
    sel2 = 2'd2;
    #1;
    chk("c3_sel2_in_ready", 64'(in_ready2), 64'b100);
    tick();
    chk("c3_sel2_out_data", 64'(out_data2), 64'd30);
    chk("c3_sel2_out_chan", 64'(out_chan2), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_mux_n.md
# rr_mux_n

Registered N-channel, W-bit selector with valid/ready handshaking on every input and on the output, and two arbitration modes. In fixed mode the channel is chosen by a select input; in round-robin mode the block arbitrates among requesting channels. It replaces the combinational 4:1 datapath selectors wherever a source may stall or a sink may apply backpressure, for example when operand buses are merged ahead of the ALU or register-file write port.

## Interface
- WIDTH, 32, data bits per channel (≥1)
- CHANNELS, 4, number of input channels (2..16)
- SEL_W, 2, select/channel-index width; must equal clog2(CHANNELS)
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset; sampled only on rising clk
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel request
- in_ready  output  CHANNELS  per-channel accept; combinational
- mode  input  1  0 = fixed select, 1 = round-robin
- sel  input  SEL_W  channel index used in fixed mode
- out_data  output  WIDTH  registered selected data
- out_chan  output  SEL_W  registered index of the source channel
- out_valid  output  1  output register holds a word
- out_ready  input  1  sink accepts the word
- stall_cnt  output  16  output-stall counter (see Configuration)

## Operation
- Single-entry output register; a transfer occurs on any edge where valid & ready.
- can_load = !out_valid | out_ready.
- Grant (combinational, one-hot or zero):
  - Fixed mode: grant[sel] = in_valid[sel]. If sel ≥ CHANNELS, there is no grant.
  - Round-robin mode: grant goes to the first i with in_valid[i], searching from ptr+1 upward and wrapping modulo CHANNELS.
- in_ready[i] = grant[i] & can_load. Inputs that are not granted see in_ready = 0 regardless of their valid.
- On input accept: out_data ← in_data[g], out_chan ← g, out_valid ← 1. In round-robin mode, ptr ← g.
- On output transfer with no input accept: out_valid ← 0. out_data and out_chan keep their last values.
- On simultaneous output transfer and input accept, the new word loads. There is no bubble, so full throughput is 1 word/cycle.
- ptr changes only on an accepted transfer in round-robin mode. Fixed-mode transfers leave ptr unchanged.
- mode and sel are sampled every cycle. Changing them never disturbs a word already held in the output register.
- Producers must hold in_data and in_valid stable until accepted. The block does not check this.
- No arithmetic is performed on the data; all widths pass through unchanged.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_chan = 0, ptr = CHANNELS-1 (so channel 0 has first priority), stall_cnt = 0.
- in_ready is 0 during any cycle in which reset is high.
- Reset asserted mid-operation discards the held word on the next edge. No transfer completes on that edge.
- Latency is 1 cycle: a word accepted at edge k appears on out_data at edge k with out_valid high, visible during cycle k+1.
- With out_ready held 0 and out_valid 1, every in_ready is 0 (full condition).
- When no in_valid is set, no grant is made, the output drains, and out_valid falls after the transfer (empty condition).

## Configuration
- RR_MUX_STALL_CNT_EN defined:
  - stall_cnt increments on each cycle where out_valid & !out_ready, and saturates at 16'hFFFF.
  - stall_cnt clears on reset only.
- RR_MUX_STALL_CNT_EN undefined: stall_cnt is tied to 16'h0000 and no counter logic is built.

## Test plan
- Fixed mode, reset, then: in_data = {200, 0, 100, 10}, all in_valid = 1, out_ready = 1, sel stepped 0→1→2→3 one per cycle → out_data = 10, 100, 0, 200 on consecutive cycles; out_chan = 0..3; in_ready one-hot matching sel.
- Round-robin mode, all four channels valid, out_ready = 1 → grant order 0, 1, 2, 3, 0, … with one word per cycle and no bubbles.
- Round-robin mode, only channels 1 and 3 valid → grants alternate 1, 3, 1, 3; channels 0 and 2 are never granted.
- Backpressure: out_ready = 0 for 5 cycles with a word held → out_data stable, all in_ready = 0, stall_cnt = 5 with RR_MUX_STALL_CNT_EN defined (0 without). Releasing out_ready then loads the next word with no bubble.
- Fixed mode, sel = 3 with CHANNELS = 3 → no in_ready is asserted and out_valid stays 0.
- Reset asserted while out_valid = 1 and out_ready = 0 → next cycle out_valid = 0, out_data = 0, ptr restored so channel 0 wins the next round-robin grant.
